// File: rtl/cpu_gen2_pkg.sv
// Shared opcode and FSM-state definitions for the second-generation accumulator core.
package cpu_gen2_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_OUT = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_STA = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_SUB = 4'h7;
  localparam logic [3:0] OP_BEQ = 4'h8;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_BNE = 4'hA;
  localparam logic [3:0] OP_BCS = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_T1   = 3'd0,
    ST_T2   = 3'd1,
    ST_T3   = 3'd2,
    ST_T4   = 3'd3,
    ST_T5   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  // Instructions whose T3 step latches the operand into MAR for a RAM access.
  function automatic logic is_mem_op(input logic [3:0] op);
    logic hit;
    case (op)
      OP_LDA, OP_ADD, OP_STA, OP_SUB, OP_CMP: hit = 1'b1;
      default:                                hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/cpu_gen2_alu.sv
// Combinational DATA_W+1 bit adder/subtractor; on subtract, carry means "no borrow" (a >= b).
module cpu_gen2_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum_s;

  // Subtract as a + ~b + 1 so the carry-out directly gives the no-borrow flag.
  always_comb begin
    sum_s = '0;
    if (sub) begin
      sum_s = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    end else begin
      sum_s = {1'b0, a} + {1'b0, b};
    end
  end

  assign result = sum_s[DATA_W-1:0];
  assign carry  = sum_s[DATA_W];
  assign zero   = (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});

endmodule

// File: rtl/cpu_gen2.sv
// Accumulator core: programmable RAM, A/B registers, Z/C flags, variable-length microcode,
// and a valid/ready output port.
module cpu_gen2
  import cpu_gen2_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted
);

  logic [DATA_W-1:0] ram_r [2**ADDR_W];

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] mar_r;
  logic [DATA_W-1:0] ir_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic              z_r;
  logic              c_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              halted_r;

  logic [3:0]        opcode_s;
  logic [ADDR_W-1:0] opnd_s;
  logic [DATA_W-1:0] ram_rdata_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] alu_result_s;
  logic              alu_carry_s;
  logic              alu_zero_s;

  assign opcode_s    = ir_r[ADDR_W+3:ADDR_W];
  assign opnd_s      = ir_r[ADDR_W-1:0];
  assign ram_rdata_s = ram_r[mar_r];

  cpu_gen2_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_r),
    .b      (b_r),
    .sub    (opcode_s != OP_ADD),
    .result (alu_result_s),
    .carry  (alu_carry_s),
    .zero   (alu_zero_s)
  );

  // RAM write port: host programming has priority; STA writes only outside reset.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = mar_r;
    ram_wdata_s = a_r;
    if (!reset) begin
      ram_we_s = 1'b0;
    end else if (prog) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = prog_addr;
      ram_wdata_s = prog_data;
    end else if (state_r == ST_T4 && opcode_s == OP_STA) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // RAM storage, deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_r[ram_waddr_s] <= ram_wdata_s;
    end else begin
      ram_r[ram_waddr_s] <= ram_r[ram_waddr_s];
    end
  end

  // Control FSM, datapath registers and output handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_T1;
      pc_r        <= '0;
      mar_r       <= '0;
      ir_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      z_r         <= 1'b0;
      c_r         <= 1'b0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      // A consumed value drops valid unless an OUT below reloads it this cycle.
      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end

      if (prog) begin
        state_r  <= ST_T1;
        pc_r     <= '0;
        halted_r <= 1'b0;
      end else begin
        case (state_r)
          ST_T1: begin
            mar_r   <= pc_r;
            state_r <= ST_T2;
          end
          ST_T2: begin
            ir_r    <= ram_rdata_s;
            pc_r    <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_r <= ST_T3;
          end
          ST_T3: begin
            state_r <= ST_T1;
            if (is_mem_op(opcode_s)) begin
              mar_r   <= opnd_s;
              state_r <= ST_T4;
            end else begin
              case (opcode_s)
                OP_OUT: begin
                  if (!out_valid_r || out_ready) begin
                    out_data_r  <= a_r;
                    out_valid_r <= 1'b1;
                  end else begin
                    state_r <= ST_T3;
                  end
                end
                OP_JMP: pc_r <= opnd_s;
                OP_LDI: a_r  <= {{(DATA_W-ADDR_W){1'b0}}, opnd_s};
                OP_BEQ: pc_r <= z_r ? opnd_s : pc_r;
                OP_BNE: pc_r <= z_r ? pc_r : opnd_s;
                OP_BCS: pc_r <= c_r ? opnd_s : pc_r;
                OP_HLT: begin
                  state_r  <= ST_HALT;
                  halted_r <= 1'b1;
                end
                default: state_r <= ST_T1;
              endcase
            end
          end
          ST_T4: begin
            state_r <= ST_T1;
            case (opcode_s)
              OP_LDA: a_r <= ram_rdata_s;
              OP_ADD, OP_SUB, OP_CMP: begin
                b_r     <= ram_rdata_s;
                state_r <= ST_T5;
              end
              default: state_r <= ST_T1;
            endcase
          end
          ST_T5: begin
            z_r     <= alu_zero_s;
            c_r     <= alu_carry_s;
            state_r <= ST_T1;
            if (opcode_s != OP_CMP) begin
              a_r <= alu_result_s;
            end else begin
              a_r <= a_r;
            end
          end
          ST_HALT: begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end
          default: state_r <= ST_T1;
        endcase
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_cpu_gen2.sv
// Directed self-checking bench for cpu_gen2 (default 8/4 instance plus a 12/6 instance).
module tb_cpu_gen2;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        halted;

  logic        prog6;
  logic [5:0]  prog_addr6;
  logic [11:0] prog_data6;
  logic [11:0] out_data6;
  logic        out_valid6;
  logic        out_ready6;
  logic        halted6;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img [16];
  logic [11:0] img6 [64];
  logic [11:0] outq [$];
  logic [11:0] outq6 [$];
  logic [11:0] expq [$];

  always #5 clk = ~clk;

  cpu_gen2 dut (
    .clk(clk), .reset(reset), .prog(prog), .prog_addr(prog_addr), .prog_data(prog_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .halted(halted)
  );

  cpu_gen2 #(.DATA_W(12), .ADDR_W(6)) dut6 (
    .clk(clk), .reset(reset), .prog(prog6), .prog_addr(prog_addr6), .prog_data(prog_data6),
    .out_data(out_data6), .out_valid(out_valid6), .out_ready(out_ready6), .halted(halted6)
  );

  // Record every accepted output word (accept happens at the following posedge).
  always @(negedge clk) begin
    if (out_valid && out_ready) outq.push_back({4'h0, out_data});
    if (out_valid6 && out_ready6) outq6.push_back(out_data6);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [11:0] got [$], input logic [11:0] exp [$]);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i), (i < got.size()) ? {20'h0, got[i]} : 32'hFFFF_FFFF,
            {20'h0, exp[i]});
    end
  endtask

  task automatic load_img();
    prog = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_addr = 4'(i);
      prog_data = img[i];
      tick();
    end
    prog = 1'b0;
    outq.delete();
  endtask

  task automatic run_to_halt(input string tag, input int max_cycles);
    int n = 0;
    while (!halted && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, {31'h0, halted}, 32'h1);
  endtask

  initial begin
    reset = 1'b0; prog = 1'b0; prog_addr = 4'h0; prog_data = 8'h00; out_ready = 1'b1;
    prog6 = 1'b1; prog_addr6 = 6'h00; prog_data6 = 12'h000; out_ready6 = 1'b1;
    tick(); tick();
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    reset = 1'b1;

    // 1: LDA 14, ADD 15, OUT, HLT -> 28+14 = 42, halted after exactly 15 cycles
    img = '{8'h1E, 8'h2F, 8'h30, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1C, 8'h0E};
    load_img();
    for (int i = 0; i < 12; i++) tick();
    check("t1_valid_c12", {31'h0, out_valid}, 32'h1);
    check("t1_data_c12", {24'h0, out_data}, 32'h2A);
    tick();
    check("t1_valid_c13", {31'h0, out_valid}, 32'h0);
    tick();
    check("t1_halted_c14", {31'h0, halted}, 32'h0);
    tick();
    check("t1_halted_c15", {31'h0, halted}, 32'h1);
    expq = '{12'h02A};
    check_outs("t1_outs", outq, expq);

    // 2a: 5-5 -> Z=1,C=1: BEQ to 6 emits 0, then BCS taken to 10 emits 3
    img = '{8'h65, 8'h7F, 8'h86, 8'h30, 8'hB8, 8'hF0, 8'h30, 8'hBA,
            8'h67, 8'h30, 8'h63, 8'h30, 8'hF0, 8'h00, 8'h00, 8'h05};
    load_img();
    run_to_halt("t2a_halt", 80);
    expq = '{12'h000, 12'h003};
    check_outs("t2a_outs", outq, expq);
    // 2b: 5-6 -> A=255, C=0, BEQ and BCS not taken
    img[15] = 8'h06;
    load_img();
    run_to_halt("t2b_halt", 80);
    expq = '{12'h0FF};
    check_outs("t2b_outs", outq, expq);

    // 3a: 200+100 -> A=44, C=1, BCS taken to OUT
    img = '{8'h1E, 8'h2F, 8'hB5, 8'hF0, 8'hF0, 8'h30, 8'hF0, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC8, 8'h64};
    load_img();
    run_to_halt("t3a_halt", 60);
    expq = '{12'h02C};
    check_outs("t3a_outs", outq, expq);
    // 3b: count 3 down by SUB of RAM=1, BNE loop exits after 3 iterations
    img = '{8'h63, 8'h30, 8'h7F, 8'hA1, 8'h30, 8'hF0, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    load_img();
    run_to_halt("t3b_halt", 120);
    expq = '{12'h003, 12'h002, 12'h001, 12'h000};
    check_outs("t3b_outs", outq, expq);

    // 4: back-pressure; second OUT stalls in T3 until out_ready rises
    img = '{8'h61, 8'h30, 8'h62, 8'h30, 8'hF0, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    out_ready = 1'b0;
    load_img();
    for (int i = 0; i < 20; i++) tick();
    check("t4_stall_data", {24'h0, out_data}, 32'h01);
    check("t4_stall_valid", {31'h0, out_valid}, 32'h1);
    check("t4_stall_halted", {31'h0, halted}, 32'h0);
    out_ready = 1'b1;
    tick();
    check("t4_release_data", {24'h0, out_data}, 32'h02);
    check("t4_release_valid", {31'h0, out_valid}, 32'h1);
    tick();
    check("t4_consumed_valid", {31'h0, out_valid}, 32'h0);
    run_to_halt("t4_halt", 40);
    expq = '{12'h001, 12'h002};
    check_outs("t4_outs", outq, expq);

    // 5: leave 42 pending, rerun and reset in ADD's T4, then rerun cleanly
    img = '{8'h1E, 8'h2F, 8'h30, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1C, 8'h0E};
    out_ready = 1'b0;
    load_img();
    run_to_halt("t5_first_halt", 40);
    check("t5_pending_valid", {31'h0, out_valid}, 32'h1);
    prog = 1'b1; prog_addr = 4'h0; prog_data = 8'h1E;
    tick();
    prog = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("t5_midrun_halted", {31'h0, halted}, 32'h0);
    reset = 1'b0;
    tick();
    check("t5_rst_data", {24'h0, out_data}, 32'h0);
    check("t5_rst_valid", {31'h0, out_valid}, 32'h0);
    check("t5_rst_halted", {31'h0, halted}, 32'h0);
    reset = 1'b1; out_ready = 1'b1;
    outq.delete();
    run_to_halt("t5_rerun_halt", 40);
    expq = '{12'h02A};
    check_outs("t5_outs", outq, expq);

    // 6: 12/6 core: JMP 63, CMP wraps PC to 0 with Z=1, STA/LDA 40 round-trips 0xABC
    for (int i = 0; i < 64; i++) img6[i] = 12'h000;
    img6[0]  = 12'h20A; img6[1]  = 12'h13F; img6[63] = 12'h27B;
    img6[10] = 12'h07C; img6[11] = 12'h168; img6[12] = 12'h180;
    img6[13] = 12'h068; img6[14] = 12'h0C0; img6[15] = 12'h3C0;
    img6[60] = 12'hABC;
    for (int i = 0; i < 64; i++) begin
      prog_addr6 = 6'(i);
      prog_data6 = img6[i];
      tick();
    end
    prog6 = 1'b0;
    outq6.delete();
    for (int n = 0; n < 120 && !halted6; n++) tick();
    check("t6_halt", {31'h0, halted6}, 32'h1);
    expq = '{12'hABC};
    check_outs("t6_outs", outq6, expq);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
